// File: rtl/sync_fifo_param_pkg.sv
// Shared defaults and helpers for the parametrised single-clock FIFO family.
// Imported by the memory, interface and top so every file agrees on sizing.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Number of entries addressed by an addr_w-bit pointer.
  function automatic int depth_f(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer side of sync_fifo_param: data, requests, control and status.
// The FIFO takes the slave view; the traffic source/sink takes the master view.
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [DATA_WIDTH-1:0] buf_in;
  logic                  wr_en;
  logic                  rd_en;
  logic                  flush;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] buf_out;
  logic                  buf_empty;
  logic                  buf_full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   fifo_counter;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output buf_in, wr_en, rd_en, flush, err_clr,
    input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );

  modport slave (
    input  buf_in, wr_en, rd_en, flush, err_clr,
    output buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// Simple dual-port register array: synchronous write, registered read with enable.
// Only the read register is reset; the storage array holds whatever was last written.
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_f(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately left out of reset so it maps onto plain
  // flops/RAM without a reset tree; occupancy tracking makes stale data unreachable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address read and write returns the old word, which is what the
  // full-FIFO simultaneous read/write case relies on.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy counter, flag decode, sticky errors.
// All status flags decode the registered counter, so no input reaches an output combinationally.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);

  localparam int DEPTH = depth_f(ADDR_WIDTH);
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  empty;
  logic                  full;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic                  mem_re;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and a latch can never be inferred.
  always_comb begin
    empty  = 1'b0;
    full   = 1'b0;
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    empty  = (count_q == '0);
    full   = (count_q == CNT_W'(DEPTH));
    rd_acc = bus.rd_en & ~empty;
    // A full FIFO can still take a write when a read frees a slot this cycle.
    wr_acc = bus.wr_en & (~full | rd_acc);
  end

  // Flush suppresses both memory ports so buf_out holds its last value.
  assign mem_we = wr_acc & ~bus.flush & ~rst;
  assign mem_re = rd_acc & ~bus.flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_acc && !rd_acc)      count_q <= count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_q <= count_q - 1'b1;
    end
  end

  // Sticky errors: a fresh error in the err_clr cycle wins. Flush clears data,
  // not history, and a flushed cycle raises no new error.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.err_clr) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end
      if (!bus.flush) begin
        if (bus.wr_en && !wr_acc) overflow_q  <= 1'b1;
        if (bus.rd_en && empty)   underflow_q <= 1'b1;
      end
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (bus.buf_in),
    .re    (mem_re),
    .raddr (rd_ptr_q),
    .rdata (bus.buf_out)
  );

  assign bus.fifo_counter = count_q;
  assign bus.buf_empty    = empty;
  assign bus.buf_full     = full;
  assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed scenarios then random traffic, every cycle
// compared against a queue-based model of the FIFO's observable behaviour.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: contents as a queue, plus last read data and sticky errors.
  logic [DW-1:0] m_q [$];
  logic [DW-1:0] m_out;
  logic          m_ov;
  logic          m_un;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = m_q.size();
    check({tag, ".count"}, 32'(bus.fifo_counter), 32'(sz));
    check({tag, ".empty"}, 32'(bus.buf_empty),    32'(sz == 0));
    check({tag, ".full"},  32'(bus.buf_full),     32'(sz == DEPTH));
    check({tag, ".ae"},    32'(bus.almost_empty), 32'(sz <= AE));
    check({tag, ".af"},    32'(bus.almost_full),  32'(sz >= AF));
    check({tag, ".out"},   32'(bus.buf_out),      32'(m_out));
    check({tag, ".ovf"},   32'(bus.overflow),     32'(m_ov));
    check({tag, ".unf"},   32'(bus.underflow),    32'(m_un));
  endtask

  task automatic drive(input logic w, input logic r, input logic f, input logic c,
                       input logic [DW-1:0] d, input logic rs);
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.flush   = f;
    bus.err_clr = c;
    bus.buf_in  = d;
    rst         = rs;
  endtask

  // One clock with the given inputs; model advances on the same edge.
  task automatic step(input string tag, input logic w, input logic r, input logic f,
                      input logic c, input logic [DW-1:0] d);
    bit was_empty, was_full, rd_ok, wr_ok;
    drive(w, r, f, c, d, 1'b0);
    @(posedge clk);
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == DEPTH);
    rd_ok     = r && !was_empty;
    wr_ok     = w && (!was_full || rd_ok);
    if (c) begin
      m_ov = 1'b0;
      m_un = 1'b0;
    end
    if (f) begin
      m_q.delete();
    end else begin
      if (w && !wr_ok) m_ov = 1'b1;
      if (r && was_empty) m_un = 1'b1;
      if (rd_ok) m_out = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    drive(w, r, 1'b0, 1'b0, d, 1'b1);
    @(posedge clk);
    m_q.delete();
    m_out = '0;
    m_ov  = 1'b0;
    m_un  = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    m_out = '0;
    m_ov  = 1'b0;
    m_un  = 1'b0;

    // T1: reset held for two clocks
    do_reset("t1_rst0", 1'b0, 1'b0, '0);
    do_reset("t1_rst1", 1'b1, 1'b1, 8'h55);

    // T2: fill with 10..80, drain in order
    for (int i = 1; i <= 8; i++) step("t2_push", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i * 10));
    check("t2_full_const", 32'(bus.buf_full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step("t2_pop", 1'b0, 1'b1, 1'b0, 1'b0, '0);
      check("t2_pop_val", 32'(bus.buf_out), 32'(i * 10));
    end

    // T3: overflow on a full FIFO, then clear
    for (int i = 1; i <= 8; i++) step("t3_fill", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i * 10));
    step("t3_push90", 1'b1, 1'b0, 1'b0, 1'b0, 8'd90);
    check("t3_ovf_const", 32'(bus.overflow), 32'd1);
    step("t3_clr", 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // T4: simultaneous read/write when full, then when empty
    step("t4_rdwr_full", 1'b1, 1'b1, 1'b0, 1'b0, 8'd99);
    check("t4_oldest_const", 32'(bus.buf_out), 32'd10);
    for (int i = 0; i < 8; i++) step("t4_drain", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step("t4_rdwr_empty", 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    check("t4_unf_const", 32'(bus.underflow), 32'd1);
    step("t4_pop5", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step("t4_clr", 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // T5: alternating push/pop across pointer wrap
    for (int i = 1; i <= 20; i++) begin
      step("t5_push", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
      step("t5_pop",  1'b0, 1'b1, 1'b0, 1'b0, '0);
    end

    // T6: flush with a concurrent write, then normal traffic
    for (int i = 1; i <= 5; i++) step("t6_fill", 1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 40));
    step("t6_flush", 1'b1, 1'b0, 1'b1, 1'b0, 8'hAA);
    step("t6_push7", 1'b1, 1'b0, 1'b0, 1'b0, 8'd7);
    step("t6_pop7",  1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("t6_out_const", 32'(bus.buf_out), 32'd7);

    // Random traffic including occasional flush, err_clr and mid-run reset
    for (int n = 0; n < 600; n++) begin
      logic          w, r, f, c;
      logic [DW-1:0] d;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 19) == 0);
      d = 8'($urandom);
      if ($urandom_range(0, 149) == 0) do_reset("rnd_rst", w, r, d);
      else                             step("rnd", w, r, f, c, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
